// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the round-robin selector arbiter.
package mux_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    BACKOFF = 2'd2
  } arb_state_t;

  // Expand a binary requester index into a one-hot grant vector.
  function automatic logic [NUM_REQ-1:0] sel_to_onehot(input logic [SEL_W-1:0] s);
    return NUM_REQ'(1) << s;
  endfunction

endpackage

// File: rtl/mux_rr_pick.sv
// Combinational rotate-priority picker: finds the first asserted request
// starting at ptr and walking upward, wrapping modulo NUM_REQ.
module mux_rr_pick
  import mux_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               found,
  output logic [SEL_W-1:0]   idx
);

  logic [SEL_W-1:0] cand;

  // Scan from the lowest-priority offset down so the highest-priority hit wins.
  always_comb begin
    found = 1'b0;
    idx   = ptr;
    cand  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = ptr + SEL_W'(i);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter and sequencer for the shared 4:1 single-bit selector.
// Grants one requester at a time, drives the select, and registers the
// selected data bit with a valid flag.
// Optional feature: define MUX_ARB_TIMEOUT_EN to revoke grants that last
// HOLD_MAX cycles, followed by a one-cycle BACKOFF gap.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int HOLD_MAX = 8,
  parameter int CNT_W    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] in,
  output logic [NUM_REQ-1:0] grant,
  output logic [SEL_W-1:0]   sel,
  output logic               busy,
  output logic               out,
  output logic               out_valid,
  output logic [CNT_W-1:0]   hold_cnt
);

  // Reject parameter combinations the hold counter cannot represent.
  if (HOLD_MAX < 2 || HOLD_MAX > 255 || (HOLD_MAX >> CNT_W) != 0) begin : g_param_check
    $error("mux_rr_arbiter: HOLD_MAX must be 2..255 and fit in CNT_W bits");
  end

  arb_state_t       state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             out_q, out_valid_q;
  logic             pick_found;
  logic [SEL_W-1:0] pick_idx;

  mux_rr_pick u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

`ifdef MUX_ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);
  logic hold_expired;
  assign hold_expired = (cnt_q == HOLD_LAST);
`endif

  // Next-state logic: arbitration points are IDLE, BACKOFF and a release in GRANT.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    case (state_q)
      GRANT: begin
        if (req[sel_q]) begin
`ifdef MUX_ARB_TIMEOUT_EN
          if (hold_expired) begin
            state_d = BACKOFF;
          end else begin
            cnt_d = cnt_inc;
          end
`else
          cnt_d = cnt_inc;
`endif
        end else if (pick_found) begin
          state_d = GRANT;
          sel_d   = pick_idx;
          ptr_d   = pick_idx + 1'b1;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        if (pick_found) begin
          state_d = GRANT;
          sel_d   = pick_idx;
          ptr_d   = pick_idx + 1'b1;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // State, pointer, counter and data register; reset drops any held grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      sel_q       <= '0;
      cnt_q       <= '0;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      out_q       <= in[sel_q];
      out_valid_q <= busy;
    end
  end

  assign busy      = (state_q == GRANT);
  assign grant     = busy ? sel_to_onehot(sel_q) : '0;
  assign sel       = sel_q;
  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign hold_cnt  = cnt_q;

endmodule

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Round-robin arbiter and sequencer for the 4:1 single-bit selector datapath. Four requesters share one output bit. The block grants one requester at a time, drives the 2-bit select, and registers the selected bit with a valid flag. It sits between the requesting agents and the downstream consumer of the shared bit.

## Interface
- HOLD_MAX, default 8: maximum grant length in cycles when timeout is compiled in; legal range 2..255.
- CNT_W, default 8: hold-counter width; must satisfy 2^CNT_W > HOLD_MAX.
- Clk  in  1  single clock; all state changes on the rising edge.
- Rst_n  in  1  synchronous active-low reset, sampled on the rising edge of Clk.
- Req  in  4  request per requester; the requester holds it high for as long as it wants the grant.
- In  in  4  data bit per requester; In[i] belongs to requester i.
- Grant  out  4  one-hot grant, or all zero.
- Sel  out  2  binary index of the current or last grantee.
- Busy  out  1  high while any Grant bit is high.
- Out  out  1  registered In[Sel], captured while Busy.
- OutValid  out  1  Out holds a sample taken under a grant.

## Operation
- States:
  - IDLE: no grant.
  - GRANT: one requester owns the selector.
  - BACKOFF: one-cycle forced gap; exists only with timeout enabled.
- Pointer `ptr[1:0]` marks the highest-priority requester. Priority order is ptr, ptr+1, ptr+2, ptr+3, wrapping mod 4.
- IDLE, any Req high: pick the first requester in priority order. Enter GRANT with Grant[k]=1 and Sel=k. Set ptr=k+1 mod 4 and clear the hold counter.
- IDLE, Req=0: stay in IDLE. Grant=0. Sel keeps its last value.
- GRANT, Req[k] still high (and no timeout): hold Grant, Sel and ptr unchanged. Counter increments and saturates at 2^CNT_W-1.
- GRANT, Req[k] low (release), other Req high: re-arbitrate in the same edge from the updated ptr, with no bubble. If none are high, go to IDLE.
- Requests that rise during GRANT are not seen until the next arbitration point.
- Datapath: every edge, Out <= In[Sel] and OutValid <= Busy.
- Rst_n low at any edge, including mid-grant: state=IDLE, ptr=0, counter=0 next cycle. Any held grant is dropped with no completion.

## Timing
- Reset values: Grant=0, Sel=0, Busy=0, Out=0, OutValid=0.
- Request to grant latency is 1 cycle: Req sampled at edge n, Grant high after edge n.
- Grant to data latency is 1 cycle: the first valid Out follows the edge after Grant rises.
- Release: Req[k] dropped before edge n, so Grant[k] is low after edge n. A successor's Grant is high after that same edge n.
- Sel and Grant change on the same edge. Sel never changes while Busy stays high with the same grantee.
- All four Req high with no release: grants rotate 0,1,2,3,0 as each holder releases.

## Configuration
- Macro MUX_ARB_TIMEOUT_EN.
- Defined: a grant whose counter reaches HOLD_MAX-1 with Req[k] still high is revoked at the next edge, so the grant lasts exactly HOLD_MAX cycles. The FSM enters BACKOFF for one cycle with Grant=0, then arbitrates from ptr. The revoked requester now has lowest priority and is re-granted only if it is the sole requester.
- Undefined: no BACKOFF state and no revocation. A grant lasts until release. The counter is still present and observable for debug, but drives no logic.

## Structure
- Shared package `mux_arb_pkg`:
  - state enum (IDLE, GRANT, BACKOFF);
  - NUM_REQ=4;
  - SEL_W=2.
- Sub-module `mux_rr_pick`: a combinational rotate-priority picker. Inputs are Req[3:0] and ptr[1:0]; outputs are a found flag and idx[1:0].
- The top level holds the FSM, pointer, counter and datapath register.

## Test plan
- Reset mid-grant: Req=0100 held 5 cycles, then Rst_n low for 1 edge. Expect Grant=0, Sel=0, OutValid=0 after that edge, then Grant=0100 again 1 cycle after Rst_n returns high.
- Single request: Req=0010 at edge 1. Expect Grant=0010, Sel=1 after edge 1. With In=0010, expect Out=1 and OutValid=1 after edge 2.
- Fairness: Req=1111 and each grantee releases after 3 cycles. Expect grant order 0,1,2,3,0 with no idle cycle between grants.
- Simultaneous release and request: requester 2 drops Req in the same cycle requester 3 raises it, ptr=3. Expect Grant=1000 on the next edge with no zero cycle.
- Timeout (MUX_ARB_TIMEOUT_EN, HOLD_MAX=4), Req=0011 held:
  - Grant=0001 for 4 cycles, then Grant=0000 for 1 cycle, then Grant=0010.
  - With Req=0001 only: 4-cycle grant, 1 gap, then re-grant to 0.
- Timeout undefined, Req=0001 held 300 cycles: Grant stays 0001 and the counter saturates at 255.
